// File: rtl/regfile_dump_unit_if.sv
// Bus bundle between the register-file dump unit and its environment.
//
// Signals (directions given for the master, i.e. the dump unit):
//   start      in   single-cycle dump request, honoured only when idle
//   abort      in   cancel the dump in progress
//   first_reg  in   first register of the range (captured on accepted start)
//   last_reg   in   last register of the range, inclusive
//   rf_addr    out  read address to the register file
//   rf_data    in   combinational register-file read data for rf_addr
//   dump_valid out  dump_data/dump_addr/dump_last are valid
//   dump_ready in   sink accepts the word on a rising edge with dump_valid
//   dump_data  out  captured register value
//   dump_addr  out  register number of dump_data
//   dump_last  out  high with the final word of the range
//   busy       out  high whenever the unit is not idle
//   done       out  one-cycle pulse when a dump completes or is rejected
//   range_err  out  sticky: first_reg > last_reg on the last accepted start
interface regfile_dump_unit_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) ();
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] first_reg;
    logic [ADDR_W-1:0] last_reg;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic              dump_valid;
    logic              dump_ready;
    logic [DATA_W-1:0] dump_data;
    logic [ADDR_W-1:0] dump_addr;
    logic              dump_last;
    logic              busy;
    logic              done;
    logic              range_err;

    modport master (
        input  start, abort, first_reg, last_reg, rf_data, dump_ready,
        output rf_addr, dump_valid, dump_data, dump_addr, dump_last,
               busy, done, range_err
    );

    modport slave (
        output start, abort, first_reg, last_reg, rf_data, dump_ready,
        input  rf_addr, dump_valid, dump_data, dump_addr, dump_last,
               busy, done, range_err
    );
endinterface

// File: rtl/regfile_dump_unit.sv
// Debug read-side master for the 32x32 register file. Walks a contiguous
// register range, reads each register through a spare read port and
// streams it out over a valid/ready channel tagged with address and a
// last flag. One word per two cycles at best (READ then SEND).
//
// Ports:
//   i_clk    clock, all state updates on the rising edge
//   i_rst_n  asynchronous active-low reset
//   io_bus   regfile_dump_unit_if.master: start/abort/range request,
//            register-file read port, dump stream and status flags
module regfile_dump_unit #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    regfile_dump_unit_if.master   io_bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_end;
    logic [DATA_W-1:0] r_dump_data;
    logic [ADDR_W-1:0] r_dump_addr;
    logic              r_valid;
    logic              r_last;
    logic              r_busy;
    logic              r_done;
    logic              r_range_err;

    // The read address is the counter itself, so it is stable for the whole
    // READ cycle and the combinational read data has settled by the edge.
    assign io_bus.rf_addr    = r_cnt;
    assign io_bus.dump_valid = r_valid;
    assign io_bus.dump_data  = r_dump_data;
    assign io_bus.dump_addr  = r_dump_addr;
    assign io_bus.dump_last  = r_last;
    assign io_bus.busy       = r_busy;
    assign io_bus.done       = r_done;
    assign io_bus.range_err  = r_range_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_end       <= '0;
            r_dump_data <= '0;
            r_dump_addr <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_range_err <= 1'b0;
        end else begin
            // done is only ever set on entry to S_DONE, giving a one-cycle pulse
            r_done <= 1'b0;

            if (io_bus.abort && (r_state != S_IDLE)) begin
                // Abort drops the word without a handshake and suppresses done;
                // range_err keeps its value from the accepted start.
                r_state <= S_IDLE;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // Abort in IDLE is a no-op, but it still blocks a start.
                        if (io_bus.start && !io_bus.abort) begin
                            r_cnt  <= io_bus.first_reg;
                            r_end  <= io_bus.last_reg;
                            r_busy <= 1'b1;
                            if (io_bus.first_reg > io_bus.last_reg) begin
                                r_range_err <= 1'b1;
                                r_done      <= 1'b1;
                                r_state     <= S_DONE;
                            end else begin
                                r_range_err <= 1'b0;
                                r_state     <= S_READ;
                            end
                        end
                    end

                    S_READ: begin
                        // A write landing on this same edge is not seen: the
                        // value captured is the one read during this cycle.
                        r_dump_data <= io_bus.rf_data;
                        r_dump_addr <= r_cnt;
                        r_last      <= (r_cnt == r_end);
                        r_valid     <= 1'b1;
                        r_state     <= S_SEND;
                    end

                    S_SEND: begin
                        if (io_bus.dump_ready) begin
                            r_valid <= 1'b0;
                            if (r_last) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                // The range check guarantees r_cnt < r_end
                                // here, so the increment cannot wrap.
                                r_cnt   <= r_cnt + ADDR_W'(1);
                                r_state <= S_READ;
                            end
                        end
                    end

                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end

                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Self-checking bench for regfile_dump_unit. A behavioural model holds the
// list of words a dump must produce (taken from the bench's register file
// when the start is accepted) and is stepped once per cycle on the falling
// edge, where the DUT outputs are compared against it.
module tb_regfile_dump_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_dump_unit_if #(.ADDR_W(5), .DATA_W(32)) u_if ();

    regfile_dump_unit #(.ADDR_W(5), .DATA_W(32)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (u_if.master)
    );

    // Register file with one write port written on the rising edge.
    logic [31:0] rf [32];
    logic        rf_init;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'hA000_0000 + 32'(i);
        end else if (wr_en) begin
            rf[wr_addr] <= wr_data;
        end
    end

    assign u_if.rf_data = rf[u_if.rf_addr];

    // ---------------- model and bookkeeping ----------------
    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
    } word_t;

    word_t q[$];
    bit    m_act;
    bit    m_dn;
    bit    m_rerr;
    int    m_gap;

    int          n_pass  = 0;
    int          n_total = 0;
    int          w_cnt, busy_cnt, done_cnt, stall_cnt;
    logic [31:0] first_data, last_data;
    logic [4:0]  last_addr;
    logic        last_flag;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    task automatic clear_stats();
        w_cnt = 0; busy_cnt = 0; done_cnt = 0; stall_cnt = 0;
        first_data = '0; last_data = '0; last_addr = '0; last_flag = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        m_act = 0; m_dn = 0; m_rerr = 0; m_gap = 0;
    endtask

    // One model step: compare the current cycle, then advance to the next.
    task automatic step();
        bit ev;
        if (!rst_n) begin
            chk("rst_valid", {31'b0, u_if.dump_valid}, 0);
            chk("rst_busy",  {31'b0, u_if.busy}, 0);
            chk("rst_done",  {31'b0, u_if.done}, 0);
            chk("rst_rerr",  {31'b0, u_if.range_err}, 0);
            chk("rst_data",  u_if.dump_data, 0);
            chk("rst_addr",  {27'b0, u_if.dump_addr}, 0);
            chk("rst_last",  {31'b0, u_if.dump_last}, 0);
            chk("rst_rfaddr", {27'b0, u_if.rf_addr}, 0);
            model_reset();
            return;
        end
        ev = m_act && (q.size() > 0) && (m_gap == 0);
        chk("busy",      {31'b0, u_if.busy}, {31'b0, m_act});
        chk("done",      {31'b0, u_if.done}, {31'b0, m_dn});
        chk("range_err", {31'b0, u_if.range_err}, {31'b0, m_rerr});
        chk("valid",     {31'b0, u_if.dump_valid}, {31'b0, ev});
        if (ev && u_if.dump_valid) begin
            chk("data", u_if.dump_data, q[0].data);
            chk("addr", {27'b0, u_if.dump_addr}, {27'b0, q[0].addr});
            chk("last", {31'b0, u_if.dump_last}, {31'b0, q[0].last});
        end
        if (u_if.busy) busy_cnt++;
        if (u_if.done) done_cnt++;
        if (u_if.dump_valid && !u_if.dump_ready) stall_cnt++;

        if (m_act && u_if.abort) begin
            q.delete(); m_act = 0; m_dn = 0; m_gap = 0;
        end else if (m_act) begin
            if (m_dn) begin
                m_act = 0; m_dn = 0;
            end else if (ev && u_if.dump_ready) begin
                if (w_cnt == 0) first_data = u_if.dump_data;
                last_data = u_if.dump_data;
                last_addr = u_if.dump_addr;
                last_flag = u_if.dump_last;
                w_cnt++;
                void'(q.pop_front());
                if (q.size() == 0) m_dn = 1;
                else m_gap = 1;
            end else if (m_gap > 0) begin
                m_gap--;
            end
        end else if (u_if.start && !u_if.abort) begin
            m_act = 1;
            if (u_if.first_reg > u_if.last_reg) begin
                m_rerr = 1; m_dn = 1;
            end else begin
                m_rerr = 0; m_gap = 1;
                for (int a = int'(u_if.first_reg); a <= int'(u_if.last_reg); a++)
                    q.push_back('{addr: 5'(a), data: rf[a], last: (a == int'(u_if.last_reg))});
            end
        end
    endtask

    // Inputs change at posedge+1; the model is stepped on the falling edge.
    task automatic cyc();
        @(negedge clk);
        step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dump(input int f, input int l);
        u_if.first_reg = 5'(f);
        u_if.last_reg  = 5'(l);
        u_if.start     = 1'b1;
        cyc();
        u_if.start     = 1'b0;
    endtask

    task automatic run_until_idle(input int limit);
        for (int k = 0; k < limit; k++) begin
            if (!m_act) break;
            cyc();
        end
        chk("timeout_idle", {31'b0, m_act}, 0);
    endtask

    int  rk;
    bit  aborted;

    initial begin
        rst_n = 1'b0; rf_init = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        u_if.start = 1'b0; u_if.abort = 1'b0; u_if.first_reg = '0;
        u_if.last_reg = '0; u_if.dump_ready = 1'b0;
        model_reset();
        clear_stats();
        cyc(); cyc();
        rst_n = 1'b1; rf_init = 1'b0;
        cyc();

        // Full range 0..31 with the sink always ready.
        clear_stats();
        u_if.dump_ready = 1'b1;
        start_dump(0, 31);
        run_until_idle(200);
        cyc();
        chk("full_words", w_cnt, 32);
        chk("full_busy_cycles", busy_cnt, 65);
        chk("full_done_pulses", done_cnt, 1);
        chk("full_first_data", first_data, 32'hA000_0000);
        chk("full_last_data", last_data, 32'hA000_001F);
        chk("full_last_addr", {27'b0, last_addr}, 31);
        chk("full_last_flag", {31'b0, last_flag}, 1);

        // Range 5..7 with ready pattern 0,0,1 per word.
        clear_stats();
        u_if.dump_ready = 1'b0;
        start_dump(5, 7);
        rk = 0;
        for (int k = 0; k < 100 && m_act; k++) begin
            if (u_if.dump_valid) begin
                u_if.dump_ready = (rk == 2);
                rk = (rk == 2) ? 0 : rk + 1;
            end else begin
                u_if.dump_ready = 1'b0;
                rk = 0;
            end
            cyc();
        end
        chk("stall_idle", {31'b0, m_act}, 0);
        cyc();
        chk("stall_words", w_cnt, 3);
        chk("stall_cycles", stall_cnt, 6);
        chk("stall_last_data", last_data, 32'hA000_0007);

        // Single word at the top of the file.
        clear_stats();
        u_if.dump_ready = 1'b1;
        start_dump(31, 31);
        run_until_idle(20);
        cyc();
        chk("single_words", w_cnt, 1);
        chk("single_addr", {27'b0, last_addr}, 31);
        chk("single_last", {31'b0, last_flag}, 1);

        // Reversed range: rejected, sticky error, then cleared by a good start.
        clear_stats();
        start_dump(9, 3);
        run_until_idle(20);
        cyc();
        chk("rev_words", w_cnt, 0);
        chk("rev_done_pulses", done_cnt, 1);
        chk("rev_range_err", {31'b0, u_if.range_err}, 1);
        start_dump(1, 1);
        run_until_idle(20);
        chk("rev_cleared", {31'b0, u_if.range_err}, 0);

        // Abort and start together while idle: nothing starts.
        u_if.abort = 1'b1;
        start_dump(0, 3);
        u_if.abort = 1'b0;
        chk("abort_idle_busy", {31'b0, u_if.busy}, 0);

        // Abort during SEND of the third word of 0..10.
        clear_stats();
        u_if.dump_ready = 1'b1;
        aborted = 0;
        start_dump(0, 10);
        for (int k = 0; k < 100; k++) begin
            if (w_cnt == 2) u_if.dump_ready = 1'b0;
            if (w_cnt == 2 && u_if.dump_valid) begin
                u_if.abort = 1'b1;
                cyc();
                u_if.abort = 1'b0;
                aborted = 1;
                break;
            end
            cyc();
        end
        chk("abort_reached", {31'b0, aborted}, 1);
        chk("abort_valid", {31'b0, u_if.dump_valid}, 0);
        chk("abort_busy", {31'b0, u_if.busy}, 0);
        chk("abort_last", {31'b0, u_if.dump_last}, 0);
        cyc(); cyc(); cyc();
        chk("abort_no_done", done_cnt, 0);
        chk("abort_words", w_cnt, 2);
        clear_stats();
        u_if.dump_ready = 1'b1;
        start_dump(0, 1);
        run_until_idle(20);
        cyc();
        chk("after_abort_words", w_cnt, 2);
        chk("after_abort_done", done_cnt, 1);

        // Start re-pulsed with another range while busy is ignored.
        clear_stats();
        u_if.dump_ready = 1'b0;
        start_dump(0, 3);
        cyc(); cyc();
        start_dump(10, 12);
        cyc();
        u_if.dump_ready = 1'b1;
        run_until_idle(50);
        cyc();
        chk("restart_words", w_cnt, 4);
        chk("restart_last_addr", {27'b0, last_addr}, 3);

        // Asynchronous reset in the middle of SEND.
        u_if.dump_ready = 1'b0;
        start_dump(0, 5);
        for (int k = 0; k < 10 && !u_if.dump_valid; k++) cyc();
        chk("pre_reset_valid", {31'b0, u_if.dump_valid}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_valid", {31'b0, u_if.dump_valid}, 0);
        chk("areset_busy", {31'b0, u_if.busy}, 0);
        chk("areset_data", u_if.dump_data, 0);
        chk("areset_rfaddr", {27'b0, u_if.rf_addr}, 0);
        model_reset();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Write to register 4 on the edge that reads it: old value captured.
        clear_stats();
        u_if.dump_ready = 1'b1;
        start_dump(4, 4);
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hDEAD_BEEF;
        cyc();
        wr_en = 1'b0;
        run_until_idle(20);
        chk("coh_old_value", first_data, 32'hA000_0004);
        clear_stats();
        start_dump(4, 4);
        run_until_idle(20);
        chk("coh_new_value", first_data, 32'hDEAD_BEEF);
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
